// File: rtl/pipe_stage_buf.sv
// In-order DEPTH-entry pipeline stage buffer with valid/ready handshake, enable stall and flush.
// Optional PIPE_STAGE_STATS_EN adds stall_cycles / flush_events counters.
module pipe_stage_buf #(
   parameter int unsigned DATA_W = 256,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         enable,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [31:0]                  stall_cycles,
   output logic [15:0]                  flush_events
`endif
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wp;
   logic [PTR_W-1:0]  rp;
   logic              push;
   logic              pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Handshake qualifiers; in_ready never depends on out_ready.
   assign in_ready  = enable && !flush && (count < CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = mem[rp];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && enable && !flush;

   always_ff @(posedge CLK) begin
      if (RST) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[PTR_W'(i)] <= '0;
         end
      end else if (flush) begin
         // Storage is deliberately left intact; only the occupancy is dropped.
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wp] <= in_data;
            wp      <= next_ptr(wp);
         end
         if (pop) begin
            rp <= next_ptr(rp);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   // Saturating observability counters, cleared by RST only.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (out_valid && !out_ready && enable && !flush && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (flush && (count != '0) && (flush_events != 16'hFFFF)) begin
            flush_events <= flush_events + 16'd1;
         end
      end
   end
`endif

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline buffer for the pipelined MIPS datapath; used between IF/ID, ID/EX, EX/MEM and MEM/WB.
- Replaces fixed-field latches with a DATA_W-wide payload, a valid/ready handshake, and a DEPTH-entry in-order queue.
- Keeps the flush/enable semantics the hazard unit already drives.
- Each stage packs its control and data fields (instr, busB, next_addr, RegWr, Wsel, ...) into one payload vector.

Parameters:
DATA_W, 256, payload width in bits (>=1)
DEPTH, 2, entries held (>=1); DEPTH=1 is a classic pipeline latch, DEPTH=2 a skid buffer

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  reset; synchronous, active-high
enable  input  1  stage advance; 0 = global stall, nothing moves
flush  input  1  synchronous clear of all held entries
in_valid  input  1  upstream payload valid
in_ready  output  1  buffer can accept this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  head entry valid
out_ready  input  1  downstream consumes head
out_data  output  DATA_W  head entry payload
count  output  $clog2(DEPTH+1)  entries currently held

Behaviour:
- Definitions: push = in_valid && in_ready; pop = out_valid && out_ready && enable && !flush.
- Storage: circular array of DEPTH entries, write pointer wp, read pointer rp, occupancy count. Pointers wrap from DEPTH-1 to 0.
- in_ready = enable && !flush && (count < DEPTH). This is combinational from registered state and inputs, with no combinational path from out_ready.
- out_valid = (count != 0). out_data = mem[rp], registered storage only. No combinational path from in_data to out_data.
- Latency: a payload accepted in cycle N appears on out_data with out_valid=1 in cycle N+1 if the buffer was empty.
- Push only: mem[wp] <= in_data; wp++; count++.
- Pop only: rp++; count--.
- Push and pop together (0 < count < DEPTH): both pointers advance; count unchanged; order preserved.
- Full (count==DEPTH): in_ready=0. A pop in that cycle frees a slot for the next cycle only.
- Empty: out_valid=0; out_ready is ignored.
- enable=0: no push, no pop. Pointers, count and storage are held. out_valid and out_data still reflect the head.
- flush=1: next cycle count=0, wp=rp=0, out_valid=0. A concurrent in_valid is dropped, since in_ready is forced 0. flush dominates enable.
- Storage contents are not cleared by flush. Stale data may remain on out_data while out_valid=0.
- RST=1: next cycle count=0, wp=rp=0, all mem entries 0. Outputs after reset: out_valid=0, out_data=0, in_ready=enable, count=0.
- RST dominates flush and enable. Reset mid-transfer discards all held entries.
- Per-edge priority: RST > flush > (push/pop).

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- When defined, two outputs are added:
  - stall_cycles (32 bits): increments each cycle out_valid && !out_ready && enable && !flush; saturates at 32'hFFFF_FFFF.
  - flush_events (16 bits): increments each cycle flush=1 && count!=0; saturates at 16'hFFFF.
- Both counters clear on RST only; flush does not clear them.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, enable=1 -> out_valid=0, out_data=0, count=0, in_ready=1.
- Single transfer, DEPTH=2:
  - stimulus: in_data=32'hDEADBEEF, in_valid=1 for one cycle, out_ready=1.
  - response: next cycle out_valid=1, out_data=DEADBEEF; following cycle out_valid=0, count=0.
- Backpressure/fill:
  - stimulus: out_ready=0; push A=1, B=2, C=3 on consecutive cycles.
  - response: A, B accepted; count=2; in_ready=0 while C is presented.
  - then out_ready=1 -> outputs 1, 2 in order; C accepted once a slot frees; output 3 follows.
- Stall: count=1 holding 5, enable=0 for 3 cycles with in_valid=1, out_ready=1 -> no pops, no pushes, out_data=5, count=1. enable=1 -> 5 popped.
- Flush priority: count=2, flush=1 together with in_valid=1 (data 9) and out_ready=1 -> next cycle count=0, out_valid=0, and 9 never appears.
- Wrap-around, DEPTH=3: stream 10 payloads 0..9 with out_ready toggling 1,0,1,0 -> outputs exactly 0..9 in order, none lost or duplicated. With PIPE_STAGE_STATS_EN, stall_cycles equals the number of out_ready=0 cycles with out_valid=1.
